// File: rtl/ibex_iob_pkg.sv
// Shared definitions for the instruction-side IOb bridge.
//   resp_tag_e : tag stored per granted fetch, selecting the response source
//   IobDataW   : IOb data width
//   IobStrbW   : IOb write-strobe width
package ibex_iob_pkg;

  typedef enum logic {
    TAG_BUS = 1'b0,
    TAG_ERR = 1'b1
  } resp_tag_e;

  localparam int unsigned IobDataW = 32;
  localparam int unsigned IobStrbW = 4;

endpackage

// File: rtl/ibex_resp_order_fifo.sv
// In-order response tag queue, MaxOutstanding entries deep, one tag per entry.
//   clk_i, rst_ni : clock, asynchronous active-low reset (empties the queue)
//   push_i        : append push_tag_i at the tail
//   push_tag_i    : tag for the new entry
//   pop_i         : drop the head entry
//   head_o        : tag at the head (TAG_BUS when empty)
//   count_o       : number of queued entries
//   any_err_o     : some queued entry is TAG_ERR
module ibex_resp_order_fifo
  import ibex_iob_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned CntW           = $clog2(MaxOutstanding + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  resp_tag_e       push_tag_i,
  input  logic            pop_i,
  output resp_tag_e       head_o,
  output logic [CntW-1:0] count_o,
  output logic            any_err_o
);

  // Entry 0 is the head. Unused entries are always TAG_BUS (0), so an
  // OR-reduction over the whole vector tells whether an ERR is queued.
  logic [MaxOutstanding-1:0] tags_q, tags_d;
  logic [CntW-1:0]           count_q, count_d;

  always_comb begin
    tags_d  = tags_q;
    count_d = count_q;
    // Pop first, then push into the freed position so a simultaneous
    // push/pop keeps the count and lands the new tag at the new tail.
    if (pop_i && (count_q != '0)) begin
      tags_d  = tags_q >> 1;
      count_d = count_q - 1'b1;
    end
    if (push_i && (count_d != CntW'(MaxOutstanding))) begin
      for (int unsigned i = 0; i < MaxOutstanding; i++) begin
        if (CntW'(i) == count_d) tags_d[i] = push_tag_i;
      end
      count_d = count_d + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tags_q  <= '0;
      count_q <= '0;
    end else begin
      tags_q  <= tags_d;
      count_q <= count_d;
    end
  end

  assign head_o    = resp_tag_e'(tags_q[0]);
  assign count_o   = count_q;
  assign any_err_o = |tags_q;

endmodule

// File: rtl/ibex_instr_iob_bridge.sv
// Instruction fetch bridge from the prefetch buffer's req/gnt/rvalid port to
// the IOb native memory interface. In-range fetches go to IOb memory;
// out-of-range fetches are answered locally with an error, in request order.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   instr_req_i/addr_i   : fetch request and word-aligned address
//   instr_gnt_o          : request accepted this cycle
//   instr_rvalid_o/rdata_o/err_o : in-order response
//   iob_valid_o/addr_o   : IOb read request (address relative to MemBase)
//   iob_wdata_o/wstrb_o  : tied 0, read-only port
//   iob_ready_i          : IOb request accepted
//   iob_rvalid_i/rdata_i : IOb read data
//   busy_o               : responses outstanding
module ibex_instr_iob_bridge
  import ibex_iob_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned AddrW          = 16,
  parameter logic [31:0] MemBase        = 32'h0000_0000,
  parameter logic [31:0] MemSize        = 32'h0001_0000
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                instr_req_i,
  input  logic [31:0]         instr_addr_i,
  output logic                instr_gnt_o,
  output logic                instr_rvalid_o,
  output logic [31:0]         instr_rdata_o,
  output logic                instr_err_o,
  output logic                iob_valid_o,
  output logic [AddrW-1:0]    iob_addr_o,
  output logic [IobDataW-1:0] iob_wdata_o,
  output logic [IobStrbW-1:0] iob_wstrb_o,
  input  logic                iob_ready_i,
  input  logic                iob_rvalid_i,
  input  logic [IobDataW-1:0] iob_rdata_i,
  output logic                busy_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic [32:0]     addr_ext, base_ext, limit_ext;
  logic [31:0]     offset;
  logic            in_range, full, err_pend, push, pop;
  logic            bus_resp, err_resp;
  resp_tag_e       head, push_tag;
  logic [CntW-1:0] count;

  // 33-bit compare so MemBase+MemSize == 2^32 does not wrap to 0.
  assign addr_ext  = {1'b0, instr_addr_i};
  assign base_ext  = {1'b0, MemBase};
  assign limit_ext = base_ext + {1'b0, MemSize};
  assign in_range  = (addr_ext >= base_ext) && (addr_ext < limit_ext);

  assign offset     = instr_addr_i - MemBase;
  assign iob_addr_o = instr_req_i ? {offset[AddrW-1:2], 2'b00} : '0;

  assign full     = (count == CntW'(MaxOutstanding));
  // No bus grant while an ERR is queued, so bus data can never arrive
  // while the head is ERR.
  assign iob_valid_o = instr_req_i & in_range & ~full & ~err_pend;
  assign instr_gnt_o = in_range ? (iob_valid_o & iob_ready_i)
                                : (instr_req_i & ~full);

  assign push     = instr_gnt_o;
  assign push_tag = in_range ? TAG_BUS : TAG_ERR;

  // Stray bus data (empty queue or ERR head) is dropped.
  assign bus_resp = busy_o && (head == TAG_BUS) && iob_rvalid_i;
  assign err_resp = busy_o && (head == TAG_ERR);
  assign pop      = bus_resp | err_resp;

  assign instr_rvalid_o = pop;
  assign instr_err_o    = err_resp;
  assign instr_rdata_o  = bus_resp ? iob_rdata_i : '0;

  assign iob_wdata_o = '0;
  assign iob_wstrb_o = '0;
  assign busy_o      = (count != '0);

  ibex_resp_order_fifo #(
    .MaxOutstanding(MaxOutstanding),
    .CntW          (CntW)
  ) u_resp_order_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push_i    (push),
    .push_tag_i(push_tag),
    .pop_i     (pop),
    .head_o    (head),
    .count_o   (count),
    .any_err_o (err_pend)
  );

endmodule
